// File: rtl/bmc_pkg.sv
// ----------------------------------------------------------------------------
// bmc_pkg
// Shared definitions for the Biphase Mark Code frame decoder:
//   - bmc_state_t   : half-bit FSM states (IDLE, H0, H1)
//   - BMC_DEFAULT_W : default decoded bits per frame
//   - bmc_decode    : decodes one bit cell from its two halves
// ----------------------------------------------------------------------------
package bmc_pkg;

   localparam int BMC_DEFAULT_W = 28;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // waiting for start of frame
      H0   = 2'd1,   // expecting first half of a cell
      H1   = 2'd2    // expecting second half of a cell
   } bmc_state_t;

   // A BMC cell carries a 1 when it toggles mid-cell, a 0 when it does not.
   function automatic logic bmc_decode(input logic first_half, input logic second_half);
      return first_half ^ second_half;
   endfunction

endpackage

// File: rtl/bmc_out_stage.sv
// ----------------------------------------------------------------------------
// bmc_out_stage
// One-entry output register with valid/ready handshake. Also decides whether
// a completed frame is presented, dropped (STRICT and erroneous) or lost
// because the held frame has not been consumed yet.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_done       : a frame completes this cycle
//   i_frame      : completed frame contents
//   i_err        : completed frame had a boundary violation
//   ready_in     : consumer accepts the held frame
//   valid_out    : o_block / o_code_err valid
//   o_block      : held frame
//   o_code_err   : held frame error flag
//   o_overflow   : one-cycle pulse, completed frame lost to backpressure
//   o_drop       : one-cycle pulse, erroneous frame discarded (STRICT)
// ----------------------------------------------------------------------------
module bmc_out_stage
   import bmc_pkg::*;
#(
   parameter int DATA_W = BMC_DEFAULT_W,
   parameter int STRICT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_done,
   input  logic [DATA_W-1:0] i_frame,
   input  logic              i_err,
   input  logic              ready_in,
   output logic              valid_out,
   output logic [DATA_W-1:0] o_block,
   output logic              o_code_err,
   output logic              o_overflow,
   output logic              o_drop
);

   logic              r_valid;
   logic [DATA_W-1:0] r_block;
   logic              r_code_err;
   logic              r_overflow;
   logic              r_drop;

   logic w_drop;
   logic w_room;

   assign w_drop = (STRICT != 0) && i_err;
   // The slot is free if empty or being emptied this very cycle.
   assign w_room = !r_valid || ready_in;

   // Output register: handshake, load, overflow and drop pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_block    <= {DATA_W{1'b0}};
         r_code_err <= 1'b0;
         r_overflow <= 1'b0;
         r_drop     <= 1'b0;
      end else begin
         r_overflow <= 1'b0;
         r_drop     <= 1'b0;
         if (r_valid && ready_in) begin
            r_valid <= 1'b0;
         end
         // A load in the same cycle as a handshake overrides the clear above.
         if (i_done) begin
            if (w_drop) begin
               r_drop <= 1'b1;
            end else if (w_room) begin
               r_valid    <= 1'b1;
               r_block    <= i_frame;
               r_code_err <= i_err;
            end else begin
               r_overflow <= 1'b1;
            end
         end
      end
   end

   assign valid_out  = r_valid;
   assign o_block    = r_block;
   assign o_code_err = r_code_err;
   assign o_overflow = r_overflow;
   assign o_drop     = r_drop;

endmodule

// File: rtl/bmc_frame_decoder.sv
// ----------------------------------------------------------------------------
// bmc_frame_decoder
// Pairs recovered half-bit samples into BMC cells, decodes each cell as
// first ^ second, checks the mandatory transition at every cell boundary and
// assembles DATA_W-bit frames presented through bmc_out_stage.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_bit       : half-bit sample
//   valid_in    : i_bit valid this cycle
//   i_sof       : sample is the first half of bit 0 (qualified by valid_in)
//   ready_in    : consumer accepts o_block
//   valid_out   : o_block / o_code_err valid
//   o_block     : decoded frame
//   o_code_err  : frame contained a boundary violation
//   o_abort     : pulse, partial frame discarded by i_sof
//   o_overflow  : pulse, completed frame lost while output held
//   o_drop      : pulse, erroneous frame discarded (STRICT)
// ----------------------------------------------------------------------------
module bmc_frame_decoder
   import bmc_pkg::*;
#(
   parameter int DATA_W     = BMC_DEFAULT_W,
   parameter int MSB_FIRST  = 1,
   parameter int CONTINUOUS = 0,
   parameter int STRICT     = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_bit,
   input  logic              valid_in,
   input  logic              i_sof,
   input  logic              ready_in,
   output logic              valid_out,
   output logic [DATA_W-1:0] o_block,
   output logic              o_code_err,
   output logic              o_abort,
   output logic              o_overflow,
   output logic              o_drop
);

   localparam int            CW       = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

   bmc_state_t        r_state;
   logic              r_first;
   logic              r_last_half;
   logic [CW-1:0]     r_bit_cnt;
   logic [DATA_W-1:0] r_shift;
   logic              r_err;
   logic              r_abort;

   logic              w_bit;
   logic [DATA_W-1:0] w_shift_nxt;
   logic              w_last_cell;
   logic              w_done;
   logic              w_abort;

   assign w_bit       = bmc_decode(r_first, i_bit);
   // MSB-first shifts left so the first bit ends at the top after DATA_W shifts.
   assign w_shift_nxt = (MSB_FIRST != 0) ? {r_shift[DATA_W-2:0], w_bit}
                                         : {w_bit, r_shift[DATA_W-1:1]};
   assign w_last_cell = (r_bit_cnt == LAST_BIT);
   assign w_done      = valid_in && !i_sof && (r_state == H1) && w_last_cell;
   // A half has been consumed in H1 always, and in H0 once past bit 0.
   // H0 with bit_cnt 0 only occurs at a CONTINUOUS seam.
   assign w_abort     = valid_in && i_sof &&
                        ((r_state == H1) ||
                         ((r_state == H0) && (r_bit_cnt != {CW{1'b0}})));

   // Half-bit FSM, cell counter, frame shift register and error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_first     <= 1'b0;
         r_last_half <= 1'b0;
         r_bit_cnt   <= {CW{1'b0}};
         r_shift     <= {DATA_W{1'b0}};
         r_err       <= 1'b0;
         r_abort     <= 1'b0;
      end else begin
         r_abort <= w_abort;
         if (valid_in) begin
            if (i_sof) begin
               // Restart from any state; bit 0 after SOF is never boundary-checked.
               r_first   <= i_bit;
               r_bit_cnt <= {CW{1'b0}};
               r_err     <= 1'b0;
               r_state   <= H1;
            end else begin
               case (r_state)
                  IDLE: begin
                     r_state <= IDLE;
                  end
                  H0: begin
                     r_first <= i_bit;
                     if (i_bit == r_last_half) begin
                        r_err <= 1'b1;
                     end
                     r_state <= H1;
                  end
                  H1: begin
                     r_shift     <= w_shift_nxt;
                     r_last_half <= i_bit;
                     if (w_last_cell) begin
                        // The out stage samples r_err this cycle; clear it
                        // for a CONTINUOUS follow-on frame.
                        r_bit_cnt <= {CW{1'b0}};
                        r_err     <= 1'b0;
                        r_state   <= (CONTINUOUS != 0) ? H0 : IDLE;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                        r_state   <= H0;
                     end
                  end
                  default: begin
                     r_state <= IDLE;
                  end
               endcase
            end
         end
      end
   end

   assign o_abort = r_abort;

   bmc_out_stage #(
      .DATA_W (DATA_W),
      .STRICT (STRICT)
   ) u_out (
      .clk        (clk),
      .rst        (rst),
      .i_done     (w_done),
      .i_frame    (w_shift_nxt),
      .i_err      (r_err),
      .ready_in   (ready_in),
      .valid_out  (valid_out),
      .o_block    (o_block),
      .o_code_err (o_code_err),
      .o_overflow (o_overflow),
      .o_drop     (o_drop)
   );

endmodule
